input_conditioner: RTL
======================

Name: input_conditioner

Overview:
Multi-channel front end for the player's push-buttons and other slow asynchronous inputs. Per channel, it provides:
- a metastability synchroniser of configurable depth;
- a consecutive-sample debouncer;
- a mode-selectable edge-pulse generator;
- a hold-to-auto-repeat pulse generator (volume/seek buttons).

It sits between the board pins and the control FSMs; every output is synchronous to clk_in.

Parameters:
- NUM_CH, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 1000, consecutive differing synchronised samples required to accept a new level (>=1)
- REPEAT_DELAY, 500000, cycles of accepted-high before the first repeat pulse (>=1)
- REPEAT_PERIOD, 100000, cycles between subsequent repeat pulses (>=1)

Ports:
- clk_in, input, 1, system clock
- reset, input, 1, asynchronous, active-high; clock clk_in
- async_in, input, NUM_CH, raw asynchronous inputs
- edge_mode, input, 2, 00 rise, 01 fall, 10 both, 11 pulses off; sampled by clk_in, assumed quasi-static
- repeat_en, input, NUM_CH, per-channel auto-repeat enable
- level_out, output, NUM_CH, debounced accepted level L
- pulse_out, output, NUM_CH, one-cycle edge pulse
- repeat_out, output, NUM_CH, one-cycle auto-repeat pulse

Behaviour:
- Reset (asynchronous): every sync flop, L, debounce count, hold count, hold phase, pulse_out and repeat_out go to 0.
- Synchroniser: chain of SYNC_STAGES flops; s = last stage.
- Debounce, each clk_in edge:
  - s == L: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: L <= s, cnt <= 0 (this is the "update").
  - else: cnt <= cnt+1.
  - Any sample with s == L clears cnt, so glitches shorter than DEBOUNCE_CYCLES are discarded entirely.
- Counter width is clog2(DEBOUNCE_CYCLES) with a minimum of 1; the counter never exceeds DEBOUNCE_CYCLES-1.
- Latency: an async_in step is reflected on level_out exactly SYNC_STAGES+DEBOUNCE_CYCLES clk_in edges after the first edge that samples the new value.
- Edge pulse:
  - pulse_out is registered and high for exactly the one cycle in which the new L first appears.
  - Condition for the pulse: update to 1 with mode 00/10, or update to 0 with mode 01/10.
  - Mode 11 never pulses.
  - edge_mode is evaluated at the update edge.
- Auto-repeat, per-channel FSM with states IDLE, DELAY, PERIOD and hold counter hc (width sized for max(REPEAT_DELAY, REPEAT_PERIOD)):
  - IDLE -> DELAY on update-to-1 while repeat_en=1; hc <= 0.
  - DELAY: hc increments; at hc == REPEAT_DELAY-1, repeat_out=1 for one cycle, hc <= 0, go to PERIOD.
  - PERIOD: at hc == REPEAT_PERIOD-1, repeat_out=1 for one cycle, hc <= 0, stay in PERIOD.
  - From any state: L==0 or repeat_en==0 -> IDLE, hc <= 0, no pulse that cycle.
  - Re-asserting repeat_en while L is already high does not restart repeat; a new rising update is required.
- Independence and simultaneous events: channels are fully independent and may pulse in the same cycle. pulse_out and repeat_out of one channel never coincide, because the first repeat fires at least REPEAT_DELAY cycles after the update.
- Reset released with async_in held high: L starts at 0, so a rising update and pulse (mode 00) occur after the normal latency. This is intended: a button held through reset registers once.
- Reset mid-debounce or mid-repeat: all progress is lost; no pulse is emitted for the interrupted event.

Decomposition:
- Shared package input_conditioner_pkg:
  - edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF);
  - repeat_state_t enum (RPT_IDLE, RPT_DELAY, RPT_PERIOD);
  - counter-width helper function.
- One sub-module, input_conditioner_ch: a single channel holding the synchroniser, debouncer, pulse logic and repeat FSM. The top generates NUM_CH instances and fans out edge_mode and the per-channel repeat_en bit.

Test Plan:
Bench parameters: NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
1. Clean step: ch0 0->1 with mode 00 -> level_out[0]=1 and a single-cycle pulse_out[0] at exactly edge 6 after the first sampling edge. Release 1->0 -> level drops at edge 6, no pulse.
2. Glitch rejection: 3-cycle high glitches separated by 1-cycle lows -> level_out and pulse_out stay 0 throughout. A 4-cycle high (after sync) -> accepted.
3. Mode coverage: repeat the press/release under modes 01, 10 and 11 -> pulses on release only; on both edges (2 pulses); never, respectively. level_out is identical in all modes.
4. Auto-repeat: repeat_en[0]=1, hold ch0 high for 40 cycles after update -> repeat_out[0] at update+10, +15, +20, +25, +30, +35, +40. Release -> no further repeats. repeat_en=0 -> no repeat_out at all.
5. Channel independence: ch0 and ch1 pressed in the same cycle -> simultaneous pulse_out=2'b11. Pressed 2 cycles apart -> pulses 2 cycles apart.
6. Reset mid-operation: assert reset during DELAY with input high -> all outputs 0 immediately. Deassert with input still high -> a fresh rising pulse after 6 edges, and the repeat schedule restarts from that update.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared types and sizing helper for the input conditioner
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_t;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_PERIOD
   } repeat_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// input_conditioner_ch: one channel - synchroniser, debouncer, edge pulse and auto-repeat
module input_conditioner_ch
   import input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 500000,
   parameter int REPEAT_PERIOD   = 100000
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       async_in,
   input  edge_mode_t mode,
   input  logic       repeat_en,
   output logic       level,
   output logic       pulse,
   output logic       rpt
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic [HW-1:0]          hc, hc_next;
   repeat_state_t          state, state_next;
   logic                   s, upd, fire, rpt_next;

   assign s    = sync[SYNC_STAGES-1];
   assign upd  = (s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign fire = upd && (s ? (mode == EDGE_RISE || mode == EDGE_BOTH)
                           : (mode == EDGE_FALL || mode == EDGE_BOTH));

   // Any sample agreeing with the accepted level restarts the debounce run.
   always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], async_in};
         cnt   <= (s == level || upd) ? '0 : cnt + CW'(1);
         level <= upd ? s : level;
         pulse <= fire;
      end

   always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
         state <= RPT_IDLE;
         hc    <= '0;
         rpt   <= 1'b0;
      end else begin
         state <= state_next;
         hc    <= hc_next;
         rpt   <= rpt_next;
      end

   // Only a fresh rising update arms the repeat; losing level or enable disarms it.
   always_comb begin
      state_next = state;
      hc_next    = '0;
      rpt_next   = 1'b0;
      if (state == RPT_IDLE)
         state_next = (upd && s && repeat_en) ? RPT_DELAY : RPT_IDLE;
      else if (!level || !repeat_en)
         state_next = RPT_IDLE;
      else begin
         rpt_next   = hc == ((state == RPT_DELAY) ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_PERIOD - 1));
         hc_next    = rpt_next ? '0 : hc + HW'(1);
         state_next = rpt_next ? RPT_PERIOD : state;
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel button front end with debounce, edge pulses and auto-repeat
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 500000,
   parameter int REPEAT_PERIOD   = 100000
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [NUM_CH-1:0] async_in,
   input  logic [1:0]        edge_mode,
   input  logic [NUM_CH-1:0] repeat_en,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] repeat_out
);

   edge_mode_t mode;

   assign mode = edge_mode_t'(edge_mode);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      input_conditioner_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk_in   (clk_in),
         .reset    (reset),
         .async_in (async_in[i]),
         .mode     (mode),
         .repeat_en(repeat_en[i]),
         .level    (level_out[i]),
         .pulse    (pulse_out[i]),
         .rpt      (repeat_out[i])
      );
   end

endmodule
